// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared definitions for the fetch stage: datapath width, pc_sel encodings,
// fetch FSM states, RV32I opcodes and the default bubble instruction.
package fetch_stall_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I major opcodes used by the front end
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = {20'h00000, 5'd0, OPC_OP_IMM};

  // Next-PC select; any code with bit 2 set is reserved
  typedef enum logic [2:0] {
    PC_SEQ  = 3'b000,
    PC_BR   = 3'b001,
    PC_JAL  = 3'b010,
    PC_JALR = 3'b011
  } pc_sel_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } fetch_state_t;

  // Force a redirect target onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word returned while decode
// is stalled. Clear wins over load.
// Ports: clk, rst_n, load, clear, din -> dout (held word), valid.
module fetch_skid_buf
  import fetch_stall_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout,
  output logic            valid
);

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Instruction-fetch PC sequencer with hazard stall, skid capture and
// redirect bubble insertion (states RUN / HOLD / BUBBLE).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   be_rdy                     back end accepts an instruction (0 = stall)
//   pc_sel                     000 seq, 001 branch, 010 jal, 011 jalr, 1xx reserved
//   br/jal/jalr_target         redirect addresses
//   imem_rdata, imem_valid     instruction memory response
//   imem_addr, imem_req        fetch address (= pc) and request
//   id_instr, id_pc, id_valid  registered decode payload
//   sel_err                    sticky reserved-pc_sel flag
//   stall_cnt                  HOLD/BUBBLE cycle counter, only when
//                              FETCH_STALL_CNT_EN is defined
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            be_rdy,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  output logic            sel_err
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [XLEN-1:0] stall_cnt
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_inc;
  logic [XLEN-1:0] id_instr_nxt, id_pc_nxt;
  logic            id_valid_nxt;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            skid_load, skid_clear, skid_v, skid_v_nxt;
  logic [XLEN-1:0] skid_word;

  assign imem_addr = pc;
  assign pc_inc    = pc + XLEN'(4);

  // Redirect decode; reserved codes fall through as sequential
  always_comb begin
    redirect = 1'b1;
    target   = br_target;
    case (pc_sel)
      PC_BR:   target = br_target;
      PC_JAL:  target = jal_target;
      PC_JALR: target = jalr_target;
      default: redirect = 1'b0;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    id_instr_nxt = id_instr;
    id_pc_nxt    = id_pc;
    id_valid_nxt = id_valid;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (redirect) begin
      pc_nxt       = word_align(target);
      skid_clear   = 1'b1;
      id_instr_nxt = NOP_INSTR;
      id_valid_nxt = 1'b0;
      state_nxt    = ST_BUBBLE;
    end else begin
      case (state)
        ST_RUN, ST_HOLD: begin
          if (!be_rdy) begin
            state_nxt = ST_HOLD;
            // Only RUN captures; a HOLD cycle leaves everything as is
            skid_load = (state == ST_RUN) && imem_valid;
          end else begin
            state_nxt = ST_RUN;
            if (state == ST_HOLD && skid_v) begin
              id_instr_nxt = skid_word;
              id_pc_nxt    = pc;
              id_valid_nxt = 1'b1;
              pc_nxt       = pc_inc;
              skid_clear   = 1'b1;
            end else if (imem_valid) begin
              id_instr_nxt = imem_rdata;
              id_pc_nxt    = pc;
              id_valid_nxt = 1'b1;
              pc_nxt       = pc_inc;
            end else begin
              id_instr_nxt = NOP_INSTR;
              id_valid_nxt = 1'b0;
            end
          end
        end
        default: begin
          // BUBBLE: one empty decode slot while the new target is fetched
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          state_nxt    = ST_RUN;
        end
      endcase
    end
  end

  assign skid_v_nxt = skid_load | (skid_v & ~skid_clear);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
      sel_err  <= 1'b0;
      imem_req <= 1'b1;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      id_instr <= id_instr_nxt;
      id_pc    <= id_pc_nxt;
      id_valid <= id_valid_nxt;
      sel_err  <= sel_err | pc_sel[2];
      // Suppress fetch only while a held word is already buffered
      imem_req <= !((state_nxt == ST_HOLD) && skid_v_nxt);
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (imem_rdata),
    .dout  (skid_word),
    .valid (skid_v)
  );

`ifdef FETCH_STALL_CNT_EN
  // Saturating count of cycles spent in HOLD or BUBBLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == ST_HOLD || state == ST_BUBBLE) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: reset, sequential fetch, hold/skid,
// redirect bubble, PC wrap, reserved pc_sel and reset during HOLD.
module tb_fetch_stall_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        be_rdy;
  logic [2:0]  pc_sel;
  logic [31:0] br_target, jal_target, jalr_target;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] id_instr, id_pc;
  logic        id_valid;
  logic        sel_err;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stall_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .be_rdy      (be_rdy),
    .pc_sel      (pc_sel),
    .br_target   (br_target),
    .jal_target  (jal_target),
    .jalr_target (jalr_target),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .sel_err     (sel_err)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [2:0] sel, input logic vld,
                       input logic [31:0] rdata);
    be_rdy     = rdy;
    pc_sel     = sel;
    imem_valid = vld;
    imem_rdata = rdata;
  endtask

  // Async reset asserted away from any edge, released on a falling edge
  task automatic do_reset();
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    br_target = 32'h0; jal_target = 32'h0; jalr_target = 32'h0;
    rst_n = 1'b1;
    #12;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_idpc: got %h want 0", id_pc); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_selerr: got %b want 0", sel_err); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      drive(1'b1, 3'b000, 1'b1, 32'hA000_0000 | exp_pc);
      cycle();
      checks++; if (id_pc !== exp_pc || id_valid !== 1'b1 || id_instr !== (32'hA000_0000 | exp_pc)) begin
        errors++; $display("FAIL seq_issue%0d: got pc=%h v=%b i=%h want pc=%h v=1 i=%h",
                           i, id_pc, id_valid, id_instr, exp_pc, 32'hA000_0000 | exp_pc);
      end
    end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr: got %h want %h", imem_addr, 32'hC); end
    // Memory not ready: bubble and PC holds
    drive(1'b1, 3'b000, 1'b0, 32'hDEAD_BEEF);
    cycle();
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 32'hC) begin
      errors++; $display("FAIL seq_novalid: got v=%b i=%h a=%h want v=0 i=%h a=%h", id_valid, id_instr, imem_addr, NOP, 32'hC);
    end
  endtask

  task automatic test_hold_skid();
    do_reset();
    drive(1'b1, 3'b000, 1'b1, 32'h1111_0000);
    cycle();
    drive(1'b1, 3'b000, 1'b1, 32'h1111_0004);
    cycle();
    checks++; if (id_pc !== 32'h4 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL hold_pre: got idpc=%h a=%h want 4 8", id_pc, imem_addr);
    end
    drive(1'b0, 3'b000, 1'b1, 32'h00A0_0093);
    cycle();
    checks++; if (id_pc !== 32'h4 || id_valid !== 1'b1 || id_instr !== 32'h1111_0004 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL hold_c1: got idpc=%h v=%b i=%h a=%h want 4 1 11110004 8", id_pc, id_valid, id_instr, imem_addr);
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
    drive(1'b0, 3'b000, 1'b0, 32'h0);
    cycle();
    checks++; if (id_pc !== 32'h4 || imem_addr !== 32'h8 || imem_req !== 1'b0) begin
      errors++; $display("FAIL hold_c2: got idpc=%h a=%h req=%b want 4 8 0", id_pc, imem_addr, imem_req);
    end
    // Release with memory idle: the skid word must be issued
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    cycle();
    checks++; if (id_instr !== 32'h00A0_0093 || id_pc !== 32'h8 || id_valid !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL hold_release: got i=%h idpc=%h v=%b a=%h want 00a00093 8 1 c", id_instr, id_pc, id_valid, imem_addr);
    end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_req_after: got %b want 1", imem_req); end
  endtask

  task automatic test_redirect();
    br_target = 32'h0000_0102;
    drive(1'b0, 3'b001, 1'b1, 32'h5555_5555);
    cycle();
    checks++; if (imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++; $display("FAIL br_c1: got a=%h v=%b want 100 0", imem_addr, id_valid);
    end
    drive(1'b1, 3'b000, 1'b1, 32'hB000_0100);
    cycle();
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 32'h100) begin
      errors++; $display("FAIL br_bubble: got v=%b i=%h a=%h want 0 %h 100", id_valid, id_instr, imem_addr, NOP);
    end
    cycle();
    checks++; if (id_pc !== 32'h100 || id_valid !== 1'b1 || id_instr !== 32'hB000_0100 || imem_addr !== 32'h104) begin
      errors++; $display("FAIL br_first: got idpc=%h v=%b i=%h a=%h want 100 1 b0000100 104", id_pc, id_valid, id_instr, imem_addr);
    end
    // Redirect arriving during BUBBLE restarts it at the newer target
    jalr_target = 32'h0000_0203;
    jal_target  = 32'h0000_0301;
    drive(1'b1, 3'b011, 1'b1, 32'h0);
    cycle();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jalr_addr: got %h want 200", imem_addr); end
    drive(1'b1, 3'b010, 1'b1, 32'h0);
    cycle();
    checks++; if (imem_addr !== 32'h300 || id_valid !== 1'b0) begin
      errors++; $display("FAIL jal_in_bubble: got a=%h v=%b want 300 0", imem_addr, id_valid);
    end
    drive(1'b1, 3'b000, 1'b1, 32'hC000_0300);
    cycle();
    checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h300) begin
      errors++; $display("FAIL jal_bubble: got v=%b a=%h want 0 300", id_valid, imem_addr);
    end
    cycle();
    checks++; if (id_pc !== 32'h300 || id_valid !== 1'b1 || id_instr !== 32'hC000_0300) begin
      errors++; $display("FAIL jal_first: got idpc=%h v=%b i=%h want 300 1 c0000300", id_pc, id_valid, id_instr);
    end
  endtask

  task automatic test_wrap();
    jalr_target = 32'hFFFF_FFFF;
    drive(1'b1, 3'b011, 1'b1, 32'h0);
    cycle();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
    drive(1'b1, 3'b000, 1'b1, 32'hE000_0000);
    cycle();
    cycle();
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap: got idpc=%h v=%b a=%h want fffffffc 1 0", id_pc, id_valid, imem_addr);
    end
  endtask

  task automatic test_sel_err();
    do_reset();
    drive(1'b1, 3'b101, 1'b1, 32'h7000_0000);
    cycle();
    checks++; if (sel_err !== 1'b1 || imem_addr !== 32'h4 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
      errors++; $display("FAIL selerr_set: got e=%b a=%h idpc=%h v=%b want 1 4 0 1", sel_err, imem_addr, id_pc, id_valid);
    end
    drive(1'b1, 3'b000, 1'b1, 32'h7000_0004);
    cycle();
    checks++; if (sel_err !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL selerr_sticky: got e=%b a=%h want 1 8", sel_err, imem_addr);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    drive(1'b0, 3'b000, 1'b1, 32'h9999_9999);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 32'h0);
    cycle();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL rsthold_async: got a=%h v=%b req=%b want 0 0 1", imem_addr, id_valid, imem_req);
    end
`ifdef FETCH_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rsthold_cnt: got %0d want 0", stall_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    cycle();
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rsthold_skid: got v=%b i=%h a=%h want 0 %h 0", id_valid, id_instr, imem_addr, NOP);
    end
  endtask

`ifdef FETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    drive(1'b0, 3'b000, 1'b0, 32'h0);
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    cycle();
    br_target = 32'h40;
    drive(1'b1, 3'b001, 1'b0, 32'h0);
    cycle();
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    cycle();
    checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL stall_cnt: got %0d want 6", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_hold_skid();
    test_redirect();
    test_wrap();
    test_sel_err();
    test_reset_mid_hold();
`ifdef FETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
